// File: rtl/pce_pad_pkg.sv
// Shared definitions for the PC Engine joypad reader and responder:
// scan states, button bit positions, nibble fields and the scan decoder.
package pce_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        DIR,
        BTN,
        DECODE,
        PUBLISH
    } state_t;

    localparam int BTN_UP     = 11;
    localparam int BTN_RIGHT  = 10;
    localparam int BTN_DOWN   = 9;
    localparam int BTN_LEFT   = 8;
    localparam int BTN_I      = 7;
    localparam int BTN_II     = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_III    = 3;
    localparam int BTN_IV     = 2;
    localparam int BTN_V      = 1;
    localparam int BTN_VI     = 0;

    localparam int NIBBLE_W      = 4;
    localparam int FIELD_DIR_LSB = 8;
    localparam int FIELD_BTN_LSB = 4;
    localparam int FIELD_EXT_LSB = 0;

    typedef struct packed {
        logic [11:0] buttons;
        logic        six_button;
        logic        frame_error;
    } scan_result_t;

    // The extended frame is recognised by its all-zero direction nibble;
    // whichever pass shows it supplies the iii..vi nibble.
    function automatic scan_result_t decode_scan(
        input logic [3:0] dir0,
        input logic [3:0] dir1,
        input logic [3:0] btn0,
        input logic [3:0] btn1
    );
        scan_result_t r;
        logic [3:0]   dir_n;
        logic [3:0]   btn_n;
        logic [3:0]   btn_x;
        r     = '0;
        dir_n = dir1;
        btn_n = btn1;
        btn_x = 4'hF;
        if (dir0 == 4'h0 && dir1 == 4'h0) begin
            r.frame_error = 1'b1;
        end else begin
            if (dir0 == 4'h0) begin
                r.six_button = 1'b1;
                btn_x        = btn0;
            end else if (dir1 == 4'h0) begin
                r.six_button = 1'b1;
                dir_n        = dir0;
                btn_n        = btn0;
                btn_x        = btn1;
            end
            r.buttons[FIELD_DIR_LSB +: NIBBLE_W] = ~dir_n;
            r.buttons[FIELD_BTN_LSB +: NIBBLE_W] = ~btn_n;
            r.buttons[FIELD_EXT_LSB +: NIBBLE_W] = ~btn_x;
        end
        return r;
    endfunction

endpackage

// File: rtl/pce_sync2.sv
// Two-flop synchronizer for an asynchronous bus whose bits are sampled
// independently (each pad line is a level, not a coherent word).
module pce_sync2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             system_clock,
    input  logic             system_reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage1_d;
    logic [WIDTH-1:0] stage2_q;
    logic [WIDTH-1:0] stage2_d;

    always_comb begin
        stage1_d = din;
        stage2_d = stage1_q;
    end

    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            stage1_q <= RESET_VAL;
            stage2_q <= RESET_VAL;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign dout = stage2_q;

endmodule

// File: rtl/pce_pad_reader.sv
// Console-side PC Engine joypad scanner: drives CLR/SEL, samples the data
// nibble over two passes and decodes a 12-bit pressed-button vector.
module pce_pad_reader
    import pce_pad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 64,
    parameter int POLL_CYCLES   = 100000,
    parameter int CNT_W         = 17
) (
    input  logic        system_clock,
    input  logic        system_reset,
    input  logic        enable,
    input  logic [3:0]  d,
    output logic        sel,
    output logic        clr,
    output logic [11:0] buttons,
    output logic        six_button,
    output logic        frame_error,
    output logic        valid
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] POLL_LAST   = CNT_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [3:0]       d_sync;
    state_t           state_q;
    state_t           state_d;
    logic             pass_q;
    logic             pass_d;
    logic [CNT_W-1:0] settle_cnt_q;
    logic [CNT_W-1:0] settle_cnt_d;
    logic [CNT_W-1:0] poll_cnt_q;
    logic [CNT_W-1:0] poll_cnt_d;
    logic             phase_last;
    logic             poll_wrap;
    logic             sel_q;
    logic             sel_d;
    logic             clr_q;
    logic             clr_d;
    logic [11:0]      buttons_q;
    logic [11:0]      buttons_d;
    logic             six_button_q;
    logic             six_button_d;
    logic             frame_error_q;
    logic             frame_error_d;
    logic             valid_q;
    logic             valid_d;
    scan_result_t     result;

    pce_sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_sync (
        .system_clock (system_clock),
        .system_reset (system_reset),
        .din          (d),
        .dout         (d_sync)
    );

    assign phase_last = (settle_cnt_q == SETTLE_LAST);
    assign poll_wrap  = (poll_cnt_q == '0);

    always_comb begin
        poll_cnt_d = (poll_cnt_q == POLL_LAST) ? '0 : poll_cnt_q + CNT_ONE;
    end

    // State register
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            state_q      <= IDLE;
            pass_q       <= 1'b0;
            settle_cnt_q <= '0;
            poll_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pass_q       <= pass_d;
            settle_cnt_q <= settle_cnt_d;
            poll_cnt_q   <= poll_cnt_d;
        end
    end

    // Next state. PUBLISH accepts a start too, so the shortest legal poll
    // period still lands every scan exactly on the counter wrap.
    always_comb begin
        state_d      = state_q;
        pass_d       = pass_q;
        settle_cnt_d = '0;
        case (state_q)
            IDLE, PUBLISH: begin
                pass_d  = 1'b0;
                state_d = (poll_wrap && enable) ? CLR : IDLE;
            end
            CLR: begin
                if (phase_last) state_d = DIR;
                else settle_cnt_d = settle_cnt_q + CNT_ONE;
            end
            DIR: begin
                if (phase_last) state_d = BTN;
                else settle_cnt_d = settle_cnt_q + CNT_ONE;
            end
            BTN: begin
                if (phase_last) begin
                    if (pass_q) begin
                        state_d = DECODE;
                    end else begin
                        state_d = CLR;
                        pass_d  = 1'b1;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_ONE;
                end
            end
            DECODE:  state_d = PUBLISH;
            default: state_d = IDLE;
        endcase
    end

    // Per-pass capture of the direction and button nibbles.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pass
            logic [3:0] dir_q;
            logic [3:0] dir_d;
            logic [3:0] btn_q;
            logic [3:0] btn_d;
            logic       this_pass;

            assign this_pass = (pass_q == 1'(gi));

            always_comb begin
                dir_d = dir_q;
                btn_d = btn_q;
                if (phase_last && this_pass) begin
                    if (state_q == DIR) dir_d = d_sync;
                    if (state_q == BTN) btn_d = d_sync;
                end
            end

            always_ff @(posedge system_clock) begin
                if (system_reset) begin
                    dir_q <= '0;
                    btn_q <= '0;
                end else begin
                    dir_q <= dir_d;
                    btn_q <= btn_d;
                end
            end
        end
    endgenerate

    assign result = decode_scan(g_pass[0].dir_q, g_pass[1].dir_q,
                                g_pass[0].btn_q, g_pass[1].btn_q);

    // Outputs. Coming out of BTN both lines would rise together, so clr is
    // held off until sel has already been high for a cycle.
    always_comb begin
        sel_d         = (state_d != BTN);
        clr_d         = (state_d == CLR) && sel_q;
        buttons_d     = buttons_q;
        six_button_d  = six_button_q;
        frame_error_d = frame_error_q;
        valid_d       = (state_q == DECODE);
        if (state_q == DECODE) begin
            buttons_d     = result.buttons;
            six_button_d  = result.six_button;
            frame_error_d = result.frame_error;
        end
    end

    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            sel_q         <= 1'b1;
            clr_q         <= 1'b0;
            buttons_q     <= '0;
            six_button_q  <= 1'b0;
            frame_error_q <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            sel_q         <= sel_d;
            clr_q         <= clr_d;
            buttons_q     <= buttons_d;
            six_button_q  <= six_button_d;
            frame_error_q <= frame_error_d;
            valid_q       <= valid_d;
        end
    end

    assign sel         = sel_q;
    assign clr         = clr_q;
    assign buttons     = buttons_q;
    assign six_button  = six_button_q;
    assign frame_error = frame_error_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_pce_pad_reader.sv
// Scoreboard bench for pce_pad_reader: pad models drive d, stimulus pushes
// hand-computed results, a negedge monitor pops and compares on valid.
module tb_pce_pad_reader;
    import pce_pad_pkg::*;

    localparam int S = 8;
    localparam int P = 6 * S + 2;
    localparam int W = 6;

    localparam logic [1:0] M_SIX  = 2'd0;
    localparam logic [1:0] M_TWO  = 2'd1;
    localparam logic [1:0] M_ZERO = 2'd2;
    localparam logic [1:0] M_ONES = 2'd3;

    logic        system_clock = 1'b0;
    logic        system_reset = 1'b1;
    logic        enable       = 1'b0;
    logic [3:0]  d;
    logic        sel;
    logic        clr;
    logic [11:0] buttons;
    logic        six_button;
    logic        frame_error;
    logic        valid;

    pce_pad_reader #(
        .SETTLE_CYCLES (S),
        .POLL_CYCLES   (P),
        .CNT_W         (W)
    ) dut (
        .system_clock (system_clock),
        .system_reset (system_reset),
        .enable       (enable),
        .d            (d),
        .sel          (sel),
        .clr          (clr),
        .buttons      (buttons),
        .six_button   (six_button),
        .frame_error  (frame_error),
        .valid        (valid)
    );

    always #5 system_clock = ~system_clock;

    // Pad models
    logic [1:0]  mode    = M_ONES;
    logic [11:0] pressed = '0;
    logic        mux;
    logic        mux_init = 1'b0;
    logic        mux_load = 1'b0;
    logic        clr_prev;

    always @(posedge system_clock) begin
        clr_prev <= clr;
        if (mux_load) mux <= mux_init;
        else if (clr && !clr_prev) mux <= ~mux;
    end

    always_comb begin
        d = 4'hF;
        case (mode)
            M_SIX: begin
                if (!mux) d = sel ? ~pressed[11:8] : ~pressed[7:4];
                else      d = sel ? 4'h0 : ~pressed[3:0];
            end
            M_TWO:   d = sel ? ~pressed[11:8] : ~pressed[7:4];
            M_ZERO:  d = 4'h0;
            default: d = 4'hF;
        endcase
    end

    // Scoreboard
    typedef struct {
        logic [11:0] b;
        logic        six;
        logic        err;
        string       name;
    } exp_t;

    exp_t q[$];
    int   errors      = 0;
    int   checks      = 0;
    int   valid_count = 0;
    int   cycle       = 0;
    int   last_valid_cycle = 0;
    int   simul_viol  = 0;
    logic mon_en      = 1'b0;
    logic sel_prev_m  = 1'b1;
    logic clr_prev_m  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge system_clock) begin
        exp_t e;
        cycle++;
        if (mon_en && sel !== sel_prev_m && clr !== clr_prev_m) simul_viol++;
        sel_prev_m = sel;
        clr_prev_m = clr;
        if (valid === 1'b1) begin
            valid_count++;
            last_valid_cycle = cycle;
            $display("scan %0d @%0d: buttons=%03h six=%0b err=%0b",
                     valid_count, cycle, buttons, six_button, frame_error);
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk({e.name, "_buttons"}, 32'(buttons), 32'(e.b));
                chk({e.name, "_six"}, 32'(six_button), 32'(e.six));
                chk({e.name, "_err"}, 32'(frame_error), 32'(e.err));
            end
        end
    end

    task automatic wait_clr(input logic level, input string what);
        int n = 0;
        while (clr !== level && n < 3 * P) begin
            @(negedge system_clock);
            n++;
        end
        chk({what, "_clr_wait"}, 32'(clr), 32'(level));
    endtask

    task automatic wait_valid(input int prev, input string what);
        int n = 0;
        while (valid_count == prev && n < 3 * P) begin
            @(negedge system_clock);
            n++;
        end
        chk({what, "_valid_seen"}, 32'(valid_count != prev), 32'd1);
    endtask

    task automatic load_pad(input logic [1:0] m, input logic [11:0] p, input logic mi);
        mode     = m;
        pressed  = p;
        mux_init = mi;
        mux_load = 1'b1;
        @(negedge system_clock);
        mux_load = 1'b0;
    endtask

    // One enabled scan: enable drops right after the scan starts.
    task automatic run_scan(input string name, input logic [1:0] m, input logic [11:0] p,
                            input logic mi, input logic [11:0] eb, input logic es, input logic ee);
        int vc;
        exp_t e;
        load_pad(m, p, mi);
        e.b = eb; e.six = es; e.err = ee; e.name = name;
        q.push_back(e);
        vc = valid_count;
        enable = 1'b1;
        wait_clr(1'b1, name);
        enable = 1'b0;
        wait_valid(vc, name);
    endtask

    initial begin
        int vc;
        int t1;
        exp_t e;

        repeat (3) @(negedge system_clock);
        chk("reset_sel", 32'(sel), 32'd1);
        chk("reset_clr", 32'(clr), 32'd0);
        chk("reset_buttons", 32'(buttons), 32'd0);
        chk("reset_six", 32'(six_button), 32'd0);
        chk("reset_err", 32'(frame_error), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        system_reset = 1'b0;
        mon_en = 1'b1;
        @(negedge system_clock);

        run_scan("six_none", M_SIX, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0);
        run_scan("six_up_i_vi", M_SIX, 12'h881, 1'b1, 12'h881, 1'b1, 1'b0);
        run_scan("six_ext_first_v", M_SIX, 12'h002, 1'b0, 12'h002, 1'b1, 1'b0);
        run_scan("two_start_left", M_TWO, 12'h110, 1'b0, 12'h110, 1'b0, 1'b0);
        run_scan("all_zero", M_ZERO, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1);
        run_scan("unplugged", M_ONES, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);

        // enable low: the last scan published once and nothing follows
        vc = valid_count;
        repeat (3 * P) @(negedge system_clock);
        chk("disabled_no_valid", 32'(valid_count), 32'(vc));

        // back-to-back scans land exactly one poll period apart
        load_pad(M_SIX, 12'h881, 1'b1);
        e.b = 12'h881; e.six = 1'b1; e.err = 1'b0; e.name = "spacing_a";
        q.push_back(e);
        e.name = "spacing_b";
        q.push_back(e);
        vc = valid_count;
        enable = 1'b1;
        wait_valid(vc, "spacing_a");
        t1 = last_valid_cycle;
        wait_clr(1'b1, "spacing_b");
        enable = 1'b0;
        vc = valid_count;
        wait_valid(vc, "spacing_b");
        chk("valid_spacing", 32'(last_valid_cycle - t1), 32'(P));

        // reset during pass 0 DIR aborts the scan silently
        load_pad(M_SIX, 12'h0F0, 1'b1);
        vc = valid_count;
        enable = 1'b1;
        wait_clr(1'b1, "abort_start");
        enable = 1'b0;
        wait_clr(1'b0, "abort_dir");
        repeat (2) @(negedge system_clock);
        system_reset = 1'b1;
        @(negedge system_clock);
        chk("abort_sel", 32'(sel), 32'd1);
        chk("abort_clr", 32'(clr), 32'd0);
        chk("abort_buttons", 32'(buttons), 32'd0);
        chk("abort_six", 32'(six_button), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        system_reset = 1'b0;
        repeat (3 * P) @(negedge system_clock);
        chk("abort_no_valid", 32'(valid_count), 32'(vc));

        chk("sel_clr_same_cycle", 32'(simul_viol), 32'd0);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
